arm_alu_issue: RTL

- Execute-stage initiator for arm_alu. It accepts one decoded data-processing instruction at a time and evaluates its ARM condition code against the architectural CPSR it owns.
- For an executing instruction it drives the ALU operand/select/cpsr_prev ports and captures alu_out and cpsr_next. It then presents the result to the register-file write port through a valid/ready handshake.
- Sits between decode/operand-fetch and the register file. It is the only writer of CPSR flags.

---
 rtl/arm_alu_issue.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/arm_alu_issue.sv
// rtl/arm_alu_issue.sv - execute-stage issue/condition/write-back control for arm_alu
//
// Accepts one decoded data-processing instruction at a time. It checks the ARM
// condition code against the CPSR held here and drives the arm_alu operand ports.
// It captures the ALU result and flags, and hands the result to the register file
// through a valid/ready handshake. This block is the only writer of the CPSR flags.
//
// Ports:
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready       instruction handshake (ready only while idle)
//   in_cond/opcode/s/rd     decoded instruction fields
//   in_op1/in_op2           Rn value and shifted operand
//   alu_op1/op2/op_sel      registered operands/opcode driven to arm_alu
//   cpsr_prev               current CPSR driven to arm_alu (same as cpsr)
//   alu_out/cpsr_next       combinational result/flags from arm_alu
//   wb_valid/wb_ready       write-back handshake
//   wb_rd/wb_data           write-back destination and value
//   cpsr                    architectural CPSR
//   stat_exec/stat_skip     executed/skipped counters (ARM_ALU_ISSUE_STATS_EN only)
//
// Optional build macro: ARM_ALU_ISSUE_STATS_EN adds the stat_exec/stat_skip counters.

`ifndef AND
`define AND 4'b0000
`define EOR 4'b0001
`define SUB 4'b0010
`define RSB 4'b0011
`define ADD 4'b0100
`define ADC 4'b0101
`define SBC 4'b0110
`define RSC 4'b0111
`define TST 4'b1000
`define TEQ 4'b1001
`define CMP 4'b1010
`define CMN 4'b1011
`define ORR 4'b1100
`define MOV 4'b1101
`define BIC 4'b1110
`define MVN 4'b1111
`endif

`ifndef CPSR_N
`define CPSR_N 31
`define CPSR_Z 30
`define CPSR_C 29
`define CPSR_V 28
`endif

module arm_alu_issue #(
    parameter logic [31:0] CPSR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_opcode,
    input  logic        in_s,
    input  logic [3:0]  in_rd,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_op_sel,
    output logic [31:0] cpsr_prev,
    input  logic [31:0] alu_out,
    input  logic [31:0] cpsr_next,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [3:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [31:0] cpsr
`ifdef ARM_ALU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_exec,
    output logic [31:0] stat_skip
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [3:0]  cond_q;
    logic        s_q;
    logic [3:0]  rd_q;

    logic        flag_n;
    logic        flag_z;
    logic        flag_c;
    logic        flag_v;
    logic        cond_pass;
    logic        is_test_op;
    logic        exec_cycle;
    logic        cpsr_load;
    logic        wb_load;
    logic        accept;

    assign flag_n = cpsr[`CPSR_N];
    assign flag_z = cpsr[`CPSR_Z];
    assign flag_c = cpsr[`CPSR_C];
    assign flag_v = cpsr[`CPSR_V];

    assign in_ready  = (state == IDLE);
    assign cpsr_prev = cpsr;
    assign accept    = in_valid && in_ready;

    // Condition evaluation against the live CPSR. Because the CPSR updates at
    // the end of EXEC, the next instruction always sees the flags just produced.
    always_comb begin
        cond_pass = 1'b0;
        case (cond_q)
            4'h0:    cond_pass = flag_z;
            4'h1:    cond_pass = !flag_z;
            4'h2:    cond_pass = flag_c;
            4'h3:    cond_pass = !flag_c;
            4'h4:    cond_pass = flag_n;
            4'h5:    cond_pass = !flag_n;
            4'h6:    cond_pass = flag_v;
            4'h7:    cond_pass = !flag_v;
            4'h8:    cond_pass = flag_c && !flag_z;
            4'h9:    cond_pass = !flag_c || flag_z;
            4'hA:    cond_pass = (flag_n == flag_v);
            4'hB:    cond_pass = (flag_n != flag_v);
            4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
            4'hD:    cond_pass = flag_z || (flag_n != flag_v);
            4'hE:    cond_pass = 1'b1;
            default: cond_pass = 1'b0; // NV: never executes
        endcase
    end

    // Compare/test opcodes only exist to set flags: they always update the
    // CPSR when they execute and never produce a register write.
    always_comb begin
        is_test_op = 1'b0;
        case (alu_op_sel)
            `TST, `TEQ, `CMP, `CMN: is_test_op = 1'b1;
            default:                is_test_op = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        exec_cycle = 1'b0;
        cpsr_load  = 1'b0;
        wb_load    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                exec_cycle = 1'b1;
                cpsr_load  = cond_pass && (s_q || is_test_op);
                wb_load    = cond_pass && !is_test_op;
                state_next = wb_load ? WB : IDLE;
            end
            WB: begin
                if (wb_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latched instruction fields; the ALU-facing copies hold after EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cond_q     <= 4'h0;
            s_q        <= 1'b0;
            rd_q       <= 4'h0;
            alu_op1    <= 32'h0;
            alu_op2    <= 32'h0;
            alu_op_sel <= 4'h0;
        end else if (accept) begin
            cond_q     <= in_cond;
            s_q        <= in_s;
            rd_q       <= in_rd;
            alu_op1    <= in_op1;
            alu_op2    <= in_op2;
            alu_op_sel <= in_opcode;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpsr <= CPSR_RESET;
        end else if (cpsr_load) begin
            cpsr <= cpsr_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid <= 1'b0;
            wb_rd    <= 4'h0;
            wb_data  <= 32'h0;
        end else if (wb_load) begin
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_data  <= alu_out;
        end else if ((state == WB) && wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

`ifdef ARM_ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_exec <= 32'h0;
            stat_skip <= 32'h0;
        end else if (exec_cycle) begin
            if (cond_pass) begin
                stat_exec <= stat_exec + 32'd1;
            end else begin
                stat_skip <= stat_skip + 32'd1;
            end
        end
    end
`else
    logic unused_exec;
    assign unused_exec = exec_cycle;
`endif

endmodule
